// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding a single FIFO write port.
// Optional lock watchdog is enabled by defining FIFO_ARB_WATCHDOG_EN.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int BW       = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ-1:0]         i_last,
  input  logic [NREQ*BW-1:0]      i_data,
  output logic [NREQ-1:0]         o_ack,
  output logic                    o_wr,
  output logic [BW-1:0]           o_data,
  input  logic                    i_full,
  output logic [$clog2(NREQ)-1:0] o_grant,
  output logic                    o_busy,
  output logic                    o_abort
);
  // state | meaning
  // IDLE  | no owner; arbitrate among i_req starting at rr_ptr
  // GRANT | o_grant owns the write port until its burst ends
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick;
  logic [GW-1:0] cand;
  logic [GW-1:0] next_ptr;
  logic [CW-1:0] beat_cnt;
  logic          owner_req;
  logic          accept;
  logic          burst_end;

  assign owner_req = i_req[o_grant];
  assign o_wr      = o_busy && owner_req;
  assign o_data    = i_data[int'(o_grant)*BW +: BW];
  assign accept    = o_wr && !i_full;
  assign burst_end = accept && (i_last[o_grant] || beat_cnt == CW'(MAXBURST - 1));
  assign next_ptr  = (o_grant == GW'(NREQ - 1)) ? '0 : o_grant + GW'(1);

  always_comb begin
    o_ack = '0;
    if (accept) o_ack[o_grant] = 1'b1;
  end

  // Walk from the farthest candidate back to rr_ptr so the nearest requester wins.
  always_comb begin
    pick = rr_ptr;
    cand = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = GW'((int'(rr_ptr) + i) % NREQ);
      if (i_req[cand]) pick = cand;
    end
  end

`ifdef FIFO_ARB_WATCHDOG_EN
  logic [3:0] wd_cnt;
  logic       abort_q;
  assign o_abort = abort_q;
`else
  assign o_abort = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      o_busy   <= 1'b0;
      rr_ptr   <= '0;
      o_grant  <= '0;
      beat_cnt <= '0;
`ifdef FIFO_ARB_WATCHDOG_EN
      wd_cnt   <= '0;
      abort_q  <= 1'b0;
`endif
    end else begin
`ifdef FIFO_ARB_WATCHDOG_EN
      abort_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|i_req) begin
            state    <= GRANT;
            o_busy   <= 1'b1;
            o_grant  <= pick;
            beat_cnt <= '0;
`ifdef FIFO_ARB_WATCHDOG_EN
            wd_cnt   <= '0;
`endif
          end
        end
        GRANT: begin
          if (accept) beat_cnt <= beat_cnt + CW'(1);
          if (burst_end) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            rr_ptr <= next_ptr;
          end
`ifdef FIFO_ARB_WATCHDOG_EN
          // Fifteenth consecutive idle owner cycle releases the lock.
          else if (owner_req) begin
            wd_cnt <= '0;
          end else if (wd_cnt == 4'd14) begin
            state   <= IDLE;
            o_busy  <= 1'b0;
            rr_ptr  <= next_ptr;
            abort_q <= 1'b1;
            wd_cnt  <= '0;
          end else begin
            wd_cnt <= wd_cnt + 4'd1;
          end
`endif
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
